// File: rtl/pc_redirect_unit_pkg.sv
// Shared encodings for the next-PC select and the fetch FSM.
// Used by the branch/jump resolution logic and the PC redirect unit.
package pc_redirect_unit_pkg;

  // EX-stage next-PC select as driven by the branch/jump resolution logic
  typedef enum logic [1:0] {
    PC_4       = 2'd0,
    PC_imm     = 2'd1,
    PC_reg_imm = 2'd2,
    PC_rsvd    = 2'd3
  } pcsrc_e;

  // Fetch-side state: one idle cycle after reset, normal run, terminal halt
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // True for the select codes that request a taken redirect
  function automatic logic is_redirect_sel(input pcsrc_e sel);
    return (sel == PC_imm) || (sel == PC_reg_imm);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_target_calc.sv
// Combinational redirect target: PC-relative or register-relative (JALR,
// bit 0 cleared), plus the misalignment flag taken from target bit 1.
module pc_target_calc
  import pc_redirect_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  pcsrc_e            pcsrc,
  input  logic [XLEN-1:0]   pc_e,
  input  logic [XLEN-1:0]   imm_e,
  input  logic [XLEN-1:0]   regimm_e,
  output logic [XLEN-1:0]   target,
  output logic              misalign
);

  logic [XLEN-1:0] jalr_mask;

  assign jalr_mask = ~XLEN'(1);

  // Select the target; sums wrap modulo 2^XLEN
  always_comb begin
    target = pc_e + imm_e;
    case (pcsrc)
      PC_imm:     target = pc_e + imm_e;
      PC_reg_imm: target = regimm_e & jalr_mask;
      default:    target = pc_e + imm_e;
    endcase
  end

  assign misalign = target[1];

endmodule

// File: rtl/pc_redirect_unit.sv
// IF program counter and redirect control. Consumes the EX-stage PCSrc
// select, loads the fetch PC, and raises IF/ID and ID/EX flushes on taken
// redirects. A redirect to a target with bit 1 set halts fetch until reset.
// Optional build macro: PC_REDIRECT_PERF_EN adds saturating RedirectCnt and
// StallCnt outputs.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        PCSrc,
  input  logic [XLEN-1:0]   PC_E,
  input  logic [XLEN-1:0]   Imm_E,
  input  logic [XLEN-1:0]   RegImm_E,
  input  logic              StallF,
  output logic [XLEN-1:0]   PC_F,
  output logic [XLEN-1:0]   PCPlus4_F,
  output logic              FetchValid,
  output logic              FlushD,
  output logic              FlushE,
  output logic              Redirect,
  output logic              MisalignErr
`ifdef PC_REDIRECT_PERF_EN
  ,
  output logic [31:0]       RedirectCnt,
  output logic [31:0]       StallCnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  pcsrc_e          sel;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            flush;

  assign sel = pcsrc_e'(PCSrc);

  pc_target_calc #(
    .XLEN (XLEN)
  ) u_target (
    .pcsrc    (sel),
    .pc_e     (PC_E),
    .imm_e    (Imm_E),
    .regimm_e (RegImm_E),
    .target   (target),
    .misalign (misalign)
  );

  // Next-state, next-PC and per-cycle control outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    FetchValid = 1'b0;
    Redirect   = 1'b0;
    flush      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        FetchValid = 1'b1;
        if (is_redirect_sel(sel)) begin
          // Redirect takes priority over StallF
          Redirect = 1'b1;
          flush    = 1'b1;
          if (misalign) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = target;
          end
        end else if (!StallF) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      HALT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign PC_F        = pc_q;
  assign PCPlus4_F   = pc_q + XLEN'(4);
  assign FlushD      = flush;
  assign FlushE      = flush;
  assign MisalignErr = err_q;

`ifdef PC_REDIRECT_PERF_EN
  // Saturating event counters: redirect cycles, and stall cycles in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RedirectCnt <= '0;
      StallCnt    <= '0;
    end else begin
      if (Redirect && (RedirectCnt != '1))
        RedirectCnt <= RedirectCnt + 32'd1;
      if ((state_q == RUN) && StallF && !Redirect && (StallCnt != '1))
        StallCnt <= StallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: a directed vector table, a few
// hand sequences (halt recovery, async reset mid-redirect, counters) and a
// randomized run against a behavioural model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] PC_E, Imm_E, RegImm_E;
  logic        StallF;
  logic [31:0] PC_F, PCPlus4_F;
  logic        FetchValid, FlushD, FlushE, Redirect, MisalignErr;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] RedirectCnt, StallCnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrc       (PCSrc),
    .PC_E        (PC_E),
    .Imm_E       (Imm_E),
    .RegImm_E    (RegImm_E),
    .StallF      (StallF),
    .PC_F        (PC_F),
    .PCPlus4_F   (PCPlus4_F),
    .FetchValid  (FetchValid),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .Redirect    (Redirect),
    .MisalignErr (MisalignErr)
`ifdef PC_REDIRECT_PERF_EN
    ,
    .RedirectCnt (RedirectCnt),
    .StallCnt    (StallCnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_booting, m_halted, m_err;
  logic [31:0] m_pc;
  longint      m_rcnt, m_scnt;

  task automatic model_reset();
    m_booting = 1; m_halted = 0; m_err = 0; m_pc = 32'h0;
    m_rcnt = 0; m_scnt = 0;
  endtask

  // Drive one cycle of inputs, compare against the model, then advance
  // the model and the simulation to the next falling edge.
  task automatic mstep(input logic [1:0] src, input logic [31:0] pce, input logic [31:0] imm,
                       input logic [31:0] rimm, input logic stall);
    bit running, redir;
    logic [31:0] tgt;
    PCSrc = src; PC_E = pce; Imm_E = imm; RegImm_E = rimm; StallF = stall;
    #1;
    running = !m_booting && !m_halted;
    redir   = running && (src == 2'd1 || src == 2'd2);
    tgt     = (src == 2'd1) ? pce + imm : rimm - (rimm % 2);
    chk("m_pc", PC_F, m_pc);
    chk("m_pc4", PCPlus4_F, m_pc + 32'd4);
    chk("m_fv", 32'(FetchValid), 32'(running));
    chk("m_redir", 32'(Redirect), 32'(redir));
    chk("m_flushd", 32'(FlushD), 32'(redir || m_halted));
    chk("m_flushe", 32'(FlushE), 32'(redir || m_halted));
    chk("m_err", 32'(MisalignErr), 32'(m_err));
`ifdef PC_REDIRECT_PERF_EN
    chk("m_rcnt", RedirectCnt, 32'(m_rcnt));
    chk("m_scnt", StallCnt, 32'(m_scnt));
    if (redir && m_rcnt < 64'hFFFF_FFFF) m_rcnt++;
    if (running && stall && !redir && m_scnt < 64'hFFFF_FFFF) m_scnt++;
`endif
    if (m_booting) m_booting = 0;
    else if (running) begin
      if (redir) begin
        if (((tgt / 2) % 2) == 1) begin m_halted = 1; m_err = 1; end
        else m_pc = tgt;
      end else if (!stall) m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  src;
    logic [31:0] pce, imm, rimm;
    logic        stall;
    logic [31:0] pc;
    logic        fv, redir, flush, err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] src, input logic [31:0] pce, input logic [31:0] imm,
                              input logic [31:0] rimm, input logic stall, input logic [31:0] pc,
                              input logic fv, input logic redir, input logic flush, input logic err);
    vec_t v;
    v.src = src; v.pce = pce; v.imm = imm; v.rimm = rimm; v.stall = stall;
    v.pc = pc; v.fv = fv; v.redir = redir; v.flush = flush; v.err = err;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    rst_n = 1'b0; PCSrc = 2'd0; PC_E = '0; Imm_E = '0; RegImm_E = '0; StallF = 1'b0;

    tbl[0]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h0,        0, 0, 0, 0); // BOOT
    tbl[1]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h0,        1, 0, 0, 0);
    tbl[2]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h4,        1, 0, 0, 0);
    tbl[3]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h8,        1, 0, 0, 0);
    tbl[4]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'hC,        1, 0, 0, 0);
    tbl[5]  = mk(2'd1, 32'h40,       32'h20, 32'h0,   0, 32'h10,       1, 1, 1, 0);
    tbl[6]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h60,       1, 0, 0, 0);
    tbl[7]  = mk(2'd2, 32'h0,        32'h0,  32'h101, 0, 32'h64,       1, 1, 1, 0);
    tbl[8]  = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h100,      1, 0, 0, 0);
    tbl[9]  = mk(2'd1, 32'h70,       32'h10, 32'h0,   1, 32'h104,      1, 1, 1, 0); // redirect beats stall
    tbl[10] = mk(2'd0, 32'h0,        32'h0,  32'h0,   1, 32'h80,       1, 0, 0, 0);
    tbl[11] = mk(2'd0, 32'h0,        32'h0,  32'h0,   1, 32'h80,       1, 0, 0, 0); // held
    tbl[12] = mk(2'd3, 32'h200,      32'h40, 32'h300, 0, 32'h80,       1, 0, 0, 0); // reserved code
    tbl[13] = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h84,       1, 0, 0, 0);
    tbl[14] = mk(2'd1, 32'hFFFF_FFF0, 32'hC, 32'h0,   0, 32'h88,       1, 1, 1, 0);
    tbl[15] = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'hFFFF_FFFC, 1, 0, 0, 0);
    tbl[16] = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h0,        1, 0, 0, 0); // wrap
    tbl[17] = mk(2'd1, 32'h10,       32'h6,  32'h0,   0, 32'h4,        1, 1, 1, 0); // misaligned 0x16
    tbl[18] = mk(2'd0, 32'h0,        32'h0,  32'h0,   0, 32'h4,        0, 0, 1, 1); // HALT
    tbl[19] = mk(2'd2, 32'h0,        32'h0,  32'h400, 0, 32'h4,        0, 0, 1, 1); // PCSrc ignored

    @(negedge clk);
    #1;
    chk("rst_pc", PC_F, 32'h0);
    chk("rst_fv", 32'(FetchValid), 32'd0);
    chk("rst_flush", 32'({FlushD, FlushE, Redirect, MisalignErr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      PCSrc = tbl[i].src; PC_E = tbl[i].pce; Imm_E = tbl[i].imm;
      RegImm_E = tbl[i].rimm; StallF = tbl[i].stall;
      #1;
      chk($sformatf("tbl%0d_pc", i), PC_F, tbl[i].pc);
      chk($sformatf("tbl%0d_pc4", i), PCPlus4_F, tbl[i].pc + 32'd4);
      chk($sformatf("tbl%0d_fv", i), 32'(FetchValid), 32'(tbl[i].fv));
      chk($sformatf("tbl%0d_redir", i), 32'(Redirect), 32'(tbl[i].redir));
      chk($sformatf("tbl%0d_flushd", i), 32'(FlushD), 32'(tbl[i].flush));
      chk($sformatf("tbl%0d_flushe", i), 32'(FlushE), 32'(tbl[i].flush));
      chk($sformatf("tbl%0d_err", i), 32'(MisalignErr), 32'(tbl[i].err));
      @(negedge clk);
    end

    // Reset pulse out of HALT returns to BOOT with the error cleared
    rst_n = 1'b0;
    #1;
    chk("halt_rst_err", 32'(MisalignErr), 32'd0);
    chk("halt_rst_flush", 32'({FlushD, FlushE}), 32'd0);
    chk("halt_rst_pc", PC_F, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mstep(2'd0, 32'h0, 32'h0, 32'h0, 0);
    mstep(2'd0, 32'h0, 32'h0, 32'h0, 0);
    mstep(2'd0, 32'h0, 32'h0, 32'h0, 0);
    mstep(2'd0, 32'h0, 32'h0, 32'h0, 0);

    // Asynchronous reset asserted between edges during a redirect
    PCSrc = 2'd1; PC_E = 32'h200; Imm_E = 32'h40; StallF = 1'b0;
    #1;
    chk("mid_redir_before", 32'(Redirect), 32'd1);
    chk("mid_pc_before", PC_F, 32'hC);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", PC_F, 32'h0);
    chk("mid_rst_flush", 32'({FlushD, FlushE, Redirect}), 32'd0);
    chk("mid_rst_fv", 32'(FetchValid), 32'd0);
    @(negedge clk);
    chk("mid_rst_hold_pc", PC_F, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Counter sequence: three redirects (one with stall) and two plain stalls
    mstep(2'd0, 32'h0,  32'h0,  32'h0,  0);
    mstep(2'd1, 32'h0,  32'h20, 32'h0,  0);
    mstep(2'd2, 32'h0,  32'h0,  32'h81, 1);
    mstep(2'd0, 32'h0,  32'h0,  32'h0,  1);
    mstep(2'd1, 32'h80, 32'h8,  32'h0,  0);
    mstep(2'd0, 32'h0,  32'h0,  32'h0,  1);
    #1;
    chk("seq_pc", PC_F, 32'h88);
`ifdef PC_REDIRECT_PERF_EN
    chk("perf_redirect_cnt", RedirectCnt, 32'd3);
    chk("perf_stall_cnt", StallCnt, 32'd2);
`endif

    // Randomized run against the model
    reset_pulse();
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  src;
      logic [31:0] pce, imm, rimm;
      logic        stall;
      if (m_halted && ($urandom_range(0, 3) == 0)) reset_pulse();
      src   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) src = 2'd0;
      pce   = $urandom & 32'hFFFF_FFFC;
      imm   = $urandom & 32'hFFFF_FFFC;
      rimm  = $urandom & 32'hFFFF_FFFD;
      if ($urandom_range(0, 19) == 0) begin
        imm  = $urandom;
        rimm = $urandom;
      end
      stall = ($urandom_range(0, 3) == 0);
      mstep(src, pce, imm, rimm, stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
